// File: rtl/axis_fifo_slice_if.sv
// AXI-Stream style payload/valid/ready bundle used on both sides of the slice.
//
// Handshake: a word moves on a rising clk edge where valid and ready are both 1.
// The sender must hold valid and data stable until that transfer happens.
// The receiver may drive ready independently of valid.
interface axis_fifo_slice_if #(
  parameter int DataWidth = 16
) ();
  logic [DataWidth-1:0] data;
  logic                 valid;
  logic                 ready;

  // The producing side drives payload and valid and samples ready.
  modport master (
    output data,
    output valid,
    input  ready
  );

  // The consuming side samples payload and valid and drives ready.
  modport slave (
    input  data,
    input  valid,
    output ready
  );
endinterface

// File: rtl/axis_fifo_slice.sv
// Register slice / small FIFO for stream stages.
// The slice drives both s_axis.ready and m_axis.valid straight from flops.
// The head word lives in a dedicated output register.
// The remaining Depth-1 words queue in a ring buffer behind it.
// A word arriving while the ring is empty goes straight into the output register,
// provided that register is empty or is being drained. This gives one cycle of latency.
module axis_fifo_slice #(
  parameter int DataWidth  = 16,
  parameter int Depth      = 4,
  parameter int AlmostFull = 3
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       flush_i,
  axis_fifo_slice_if.slave           s_axis,
  axis_fifo_slice_if.master          m_axis,
  output logic [$clog2(Depth+1)-1:0] count_o,
  output logic                       almost_full_o
);

  localparam int CntW      = $clog2(Depth + 1);
  localparam int RingDepth = Depth - 1;
  localparam int PtrW      = (RingDepth > 1) ? $clog2(RingDepth) : 1;

  // Ring pointers wrap at RingDepth. RingDepth is generally not a power of two.
  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    if (p == PtrW'(RingDepth - 1)) begin
      return '0;
    end
    return p + PtrW'(1);
  endfunction

  logic [DataWidth-1:0] ring_q [RingDepth];
  logic [DataWidth-1:0] out_data_q;
  logic [PtrW-1:0]      wr_ptr_q;
  logic [PtrW-1:0]      rd_ptr_q;
  logic [CntW-1:0]      count_q;
  logic [CntW-1:0]      count_next;
  logic [CntW-1:0]      ring_cnt;
  logic                 s_ready_q;
  logic                 m_valid_q;

  logic wr;
  logic rd;
  logic ring_empty;
  logic out_load;
  logic ring_pop;
  logic bypass;
  logic ring_push;

  // Decode this cycle's transfers and decide where the incoming word goes.
  // The output register holds a word whenever count_q is non-zero.
  // The ring therefore holds count_q minus that one word.
  always_comb begin
    wr         = s_axis.valid & s_ready_q;
    rd         = m_valid_q & m_axis.ready;
    ring_cnt   = count_q - CntW'(m_valid_q);
    ring_empty = (ring_cnt == '0);
    out_load   = !m_valid_q || rd;
    ring_pop   = out_load && !ring_empty;
    bypass     = out_load && ring_empty && wr;
    ring_push  = wr && !bypass;
    count_next = count_q + CntW'(wr) - CntW'(rd);
  end

  // Control state. Flush has the same effect as reset, and any transfer in that cycle is dropped.
  always_ff @(posedge clk_i) begin
    if (!rst_ni || flush_i) begin
      count_q   <= '0;
      s_ready_q <= 1'b1;
      m_valid_q <= 1'b0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
    end else begin
      count_q   <= count_next;
      s_ready_q <= (count_next != CntW'(Depth));
      m_valid_q <= (count_next != '0);
      if (ring_push) begin
        wr_ptr_q <= ptr_inc(wr_ptr_q);
      end
      if (ring_pop) begin
        rd_ptr_q <= ptr_inc(rd_ptr_q);
      end
    end
  end

  // Payload storage has no reset. Stale contents are masked by the cleared valid and count.
  always_ff @(posedge clk_i) begin
    if (ring_push) begin
      ring_q[wr_ptr_q] <= s_axis.data;
    end
    if (ring_pop) begin
      out_data_q <= ring_q[rd_ptr_q];
    end else if (bypass) begin
      out_data_q <= s_axis.data;
    end
  end

  assign s_axis.ready  = s_ready_q;
  assign m_axis.valid  = m_valid_q;
  assign m_axis.data   = out_data_q;
  assign count_o       = count_q;
  assign almost_full_o = (count_q >= CntW'(AlmostFull));

endmodule

// File: tb/tb_axis_fifo_slice.sv
// Bench for axis_fifo_slice: directed fill/drain/stream/flush plus random back-pressure.
// Expected behaviour comes from a queue of accepted words.
module tb_axis_fifo_slice;
  localparam int W     = 16;
  localparam int Depth = 4;
  localparam int AF    = 3;
  localparam int CntW  = $clog2(Depth + 1);

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  logic flush;
  always #5 clk = ~clk;

  axis_fifo_slice_if #(.DataWidth(W)) s_if ();
  axis_fifo_slice_if #(.DataWidth(W)) m_if ();
  logic [CntW-1:0] count_o;
  logic            almost_full_o;

  axis_fifo_slice #(.DataWidth(W), .Depth(Depth), .AlmostFull(AF)) dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .flush_i       (flush),
    .s_axis        (s_if),
    .m_axis        (m_if),
    .count_o       (count_o),
    .almost_full_o (almost_full_o)
  );

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  int n_checks = 0;
  int n_pass   = 0;
  int n_in     = 0;
  int n_out    = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end else begin
      n_pass++;
    end
  endtask

  // Outputs follow directly from how many words are held and which one is oldest.
  task automatic check_outputs();
    check("s_ready", 32'(s_if.ready), 32'(exp_q.size() != Depth));
    check("m_valid", 32'(m_if.valid), 32'(exp_q.size() != 0));
    check("count", 32'(count_o), 32'(exp_q.size()));
    check("almost_full", 32'(almost_full_o), 32'(exp_q.size() >= AF));
    if (exp_q.size() != 0) begin
      check("m_data", 32'(m_if.data), 32'(exp_q[0]));
    end
  endtask

  // ---------------- driver ----------------
  // Drives one clock cycle and checks outputs on the falling edge.
  // The model is updated at the rising edge.
  task automatic drive_cycle(input logic sv, input logic [W-1:0] sd, input logic mr,
                             input logic fl);
    bit acc;
    bit dlv;
    s_if.valid = sv;
    s_if.data  = sd;
    m_if.ready = mr;
    flush      = fl;
    @(negedge clk);
    check_outputs();
    acc = sv && (exp_q.size() != Depth);
    dlv = mr && (exp_q.size() != 0);
    @(posedge clk);
    #1;
    if (fl) begin
      exp_q.delete();
    end else begin
      if (dlv) begin
        void'(exp_q.pop_front());
        n_out++;
      end
      if (acc) begin
        exp_q.push_back(sd);
        n_in++;
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int guard;
    // 1: reset held two cycles with upstream valid asserted
    rst_n      = 1'b0;
    flush      = 1'b0;
    s_if.valid = 1'b1;
    s_if.data  = 16'h1234;
    m_if.ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_s_ready", 32'(s_if.ready), 32'd1);
    check("rst_m_valid", 32'(m_if.valid), 32'd0);
    check("rst_count", 32'(count_o), 32'd0);
    check("rst_almost_full", 32'(almost_full_o), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // 2: fill with the sink stalled; the fifth word must be held off
    drive_cycle(1'b1, 16'h0011, 1'b0, 1'b0);
    drive_cycle(1'b1, 16'h0022, 1'b0, 1'b0);
    drive_cycle(1'b1, 16'h0033, 1'b0, 1'b0);
    check("fill_af_at3", 32'(almost_full_o), 32'd1);
    drive_cycle(1'b1, 16'h0044, 1'b0, 1'b0);
    check("fill_count4", 32'(count_o), 32'd4);
    check("fill_ready0", 32'(s_if.ready), 32'd0);
    drive_cycle(1'b1, 16'h0055, 1'b0, 1'b0);
    check("fill_held_off", 32'(count_o), 32'd4);

    // 3: drain in order, one word per cycle
    drive_cycle(1'b0, 16'h0000, 1'b1, 1'b0);
    check("drain_ready_back", 32'(s_if.ready), 32'd1);
    repeat (4) drive_cycle(1'b0, 16'h0000, 1'b1, 1'b0);
    check("drain_empty", 32'(m_if.valid), 32'd0);

    // 4: full-rate streaming, data = cycle index
    for (int i = 0; i < 100; i++) begin
      drive_cycle(1'b1, W'(i), 1'b1, 1'b0);
      check("stream_count", 32'(count_o), 32'd1);
    end
    drive_cycle(1'b0, 16'h0000, 1'b1, 1'b0);

    // 5: random valid/ready against the queue model
    n_in  = 0;
    n_out = 0;
    guard = 0;
    while (n_in < 10000 && guard < 60000) begin
      drive_cycle(1'($urandom_range(0, 1)), W'($urandom_range(0, 16'hFFFF)),
                  1'($urandom_range(0, 1)), 1'b0);
      guard++;
    end
    check("random_budget", 32'(n_in >= 10000), 32'd1);
    repeat (Depth + 2) drive_cycle(1'b0, 16'h0000, 1'b1, 1'b0);
    check("random_delivered", 32'(n_out), 32'(n_in));

    // 6: flush with three words held and a write offered in the same cycle
    drive_cycle(1'b1, 16'h00A1, 1'b0, 1'b0);
    drive_cycle(1'b1, 16'h00A2, 1'b0, 1'b0);
    drive_cycle(1'b1, 16'h00A3, 1'b0, 1'b0);
    check("flush_pre_count", 32'(count_o), 32'd3);
    drive_cycle(1'b1, 16'h00AA, 1'b0, 1'b1);
    check("flush_count", 32'(count_o), 32'd0);
    check("flush_m_valid", 32'(m_if.valid), 32'd0);
    check("flush_s_ready", 32'(s_if.ready), 32'd1);
    repeat (3) drive_cycle(1'b0, 16'h0000, 1'b1, 1'b0);

    // ---------------- report ----------------
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
